// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
//   Pays out change in 25c/10c/5c coins with a greedy algorithm. Each coin is
//   requested from a hopper one at a time. The request is held until the
//   hopper acknowledges it, or until ACK_TIMEOUT cycles pass without an ack.
//
// Parameters
//   ACK_TIMEOUT : cycles in REQ without hopper_ack before the payout faults
//
// Ports
//   clk        in   single clock, rising edge
//   reset      in   asynchronous, active-high
//   start      in   one-cycle payout request, samples amount (ignored while busy)
//   amount     in   [4:0] change owed in cents
//   hopper_ack in   hopper released the coin currently requested
//   coin_req   out  [2:0] one-hot {25c,10c,5c}, high only while requesting
//   busy       out  high whenever the FSM is not idle
//   done       out  one-cycle pulse on successful completion
//   err        out  one-cycle pulse on invalid amount or hopper timeout
//   coins_paid out  [2:0] coins acknowledged in the current/last transaction
// ---------------------------------------------------------------------------
module change_dispenser #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] amount,
  input  logic       hopper_ack,
  output logic [2:0] coin_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [2:0] coins_paid
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [2:0] COIN_25 = 3'b100;
  localparam logic [2:0] COIN_10 = 3'b010;
  localparam logic [2:0] COIN_5  = 3'b001;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    REQ,
    DONE,
    FAULT
  } state_t;

  state_t         state_reg, state_next;
  logic [4:0]     remaining_reg, remaining_next;
  logic [2:0]     coin_sel_reg, coin_sel_next;
  logic [TW-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic [2:0]     coins_paid_reg, coins_paid_next;
  logic [2:0]     coin_req_reg, coin_req_next;
  logic           busy_reg, busy_next;
  logic           done_reg, done_next;
  logic           err_reg, err_next;
  logic [4:0]     coin_value;

  // Value in cents of the currently selected coin.
  always_comb begin
    case (coin_sel_reg)
      COIN_25: coin_value = 5'd25;
      COIN_10: coin_value = 5'd10;
      default: coin_value = 5'd5;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    remaining_next  = remaining_reg;
    coin_sel_next   = coin_sel_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    coins_paid_next = coins_paid_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          coins_paid_next = 3'd0;
          if (amount == 5'd0) begin
            state_next = DONE;
          end else if ((amount % 5'd5) != 5'd0) begin
            state_next = FAULT;
          end else begin
            remaining_next = amount;
            state_next     = CALC;
          end
        end
      end

      CALC: begin
        tmo_cnt_next = '0;
        if (remaining_reg == 5'd0) begin
          state_next = DONE;
        end else begin
          if (remaining_reg >= 5'd25)      coin_sel_next = COIN_25;
          else if (remaining_reg >= 5'd10) coin_sel_next = COIN_10;
          else                             coin_sel_next = COIN_5;
          state_next = REQ;
        end
      end

      REQ: begin
        // An ack in the final timeout cycle still counts as a payout.
        if (hopper_ack) begin
          remaining_next  = remaining_reg - coin_value;
          coins_paid_next = coins_paid_reg + 3'd1;
          tmo_cnt_next    = '0;
          state_next      = CALC;
        end else if (tmo_cnt_reg == TW'(ACK_TIMEOUT - 1)) begin
          tmo_cnt_next = '0;
          state_next   = FAULT;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      FAULT: begin
        remaining_next = 5'd0;
        state_next     = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    coin_req_next = (state_next == REQ) ? coin_sel_next : 3'b000;
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE);
    err_next      = (state_next == FAULT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      remaining_reg  <= 5'd0;
      coin_sel_reg   <= 3'b000;
      tmo_cnt_reg    <= '0;
      coins_paid_reg <= 3'd0;
      coin_req_reg   <= 3'b000;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      remaining_reg  <= remaining_next;
      coin_sel_reg   <= coin_sel_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      coins_paid_reg <= coins_paid_next;
      coin_req_reg   <= coin_req_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  assign coin_req   = coin_req_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign coins_paid = coins_paid_reg;

endmodule
